mult_div: RTL

Iterative multiply/divide unit in the EX stage, directly downstream of the ID-stage funct generation. It consumes the decoded `funct` with the two ALU operands, and executes MULT/MULTU/DIV/DIVU over multiple cycles. It owns the architectural HI/LO registers, services MTHI/MTLO/MFHI/MFLO, and raises a stall request to the pipeline controller while an operation is in flight.

---
 rtl/mult_div.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle over 32 cycles.
module mult_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic [5:0]  funct,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  output logic        stall_req,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state_o
);

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] hi_q, lo_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] opb_q;
  logic        neg_q;
  logic        rem_neg_q;

  logic        is_mul, is_div, is_signed, start;
  logic        op1_neg, op2_neg;
  logic [31:0] mag1, mag2;
  logic [32:0] mul_sum, div_trial, div_diff;
  logic        div_ge;
  logic [63:0] acc_d;
  logic [63:0] prod_final;
  logic [31:0] quo_final, rem_final;

  always_comb begin
    is_mul    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    is_div    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    is_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    start     = (state_q == S_IDLE) && en && !flush && (is_mul || is_div);
    op1_neg   = is_signed && operand_1[31];
    op2_neg   = is_signed && operand_2[31];
    mag1      = op1_neg ? -operand_1 : operand_1;
    mag2      = op2_neg ? -operand_2 : operand_2;

    // acc_q holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    div_trial = {acc_q[63:32], acc_q[31]};
    div_diff  = div_trial - {1'b0, opb_q};
    div_ge    = !div_diff[32];

    if (state_q == S_MUL) begin
      acc_d = {mul_sum, acc_q[31:1]};
    end else begin
      acc_d = {(div_ge ? div_diff[31:0] : div_trial[31:0]), acc_q[30:0], div_ge};
    end

    prod_final = neg_q ? -acc_d : acc_d;
    quo_final  = neg_q ? -acc_d[31:0] : acc_d[31:0];
    rem_final  = rem_neg_q ? -acc_d[63:32] : acc_d[63:32];

    // A flush in the busy states releases the pipeline in the same cycle
    stall_req = !rst && (start || (((state_q == S_MUL) || (state_q == S_DIV)) && !flush));

    result = 32'd0;
    if (funct == FUNCT_MFHI) result = hi_q;
    else if (funct == FUNCT_MFLO) result = lo_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opb_q     <= 32'd0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            neg_q     <= op1_neg ^ op2_neg;
            rem_neg_q <= is_div && op1_neg;
            cnt_q     <= 5'd0;
            acc_q     <= {32'd0, mag1};
            opb_q     <= mag2;
            if (is_div && (operand_2 == 32'd0)) begin
              hi_q    <= operand_1;
              lo_q    <= 32'hFFFF_FFFF;
              state_q <= S_DONE;
            end else begin
              state_q <= is_mul ? S_MUL : S_DIV;
            end
          end else if (en && !flush) begin
            if (funct == FUNCT_MTHI) hi_q <= operand_1;
            if (funct == FUNCT_MTLO) lo_q <= operand_1;
          end
        end
        S_MUL, S_DIV: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              if (state_q == S_MUL) begin
                hi_q <= prod_final[63:32];
                lo_q <= prod_final[31:0];
              end else begin
                hi_q <= rem_final;
                lo_q <= quo_final;
              end
              state_q <= S_DONE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = state_q;

endmodule
